// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_pkg
//  Description : Shared types and constants for the SCCB configuration
//                sequencer and its default register table.
//  Revision    : 1.0 - initial release
// ============================================================================
package sccb_pkg;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DELAY     = 3'd5,
        ST_NEXT      = 3'd6,
        ST_FINISH    = 3'd7
    } seq_state_t;

    // Table markers
    localparam logic [15:0] END_MARKER     = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG      = 8'hFF;

    // SCCB write device ID of the OV7670
    localparam logic [7:0]  DEV_ID_DEFAULT = 8'h42;

    // OV7670 register addresses used by the default table
    localparam logic [7:0]  REG_COM3  = 8'h0C;
    localparam logic [7:0]  REG_CLKRC = 8'h11;
    localparam logic [7:0]  REG_COM7  = 8'h12;
    localparam logic [7:0]  REG_COM10 = 8'h15;
    localparam logic [7:0]  REG_TSLB  = 8'h3A;
    localparam logic [7:0]  REG_COM15 = 8'h40;

endpackage
`default_nettype wire

// File: rtl/sccb_cfg_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_cfg_rom
//  Description : Default OV7670 register table, synchronous read with one
//                cycle of latency. Entries are {reg_addr, reg_data}.
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_50,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);

    // Registered table lookup; unused locations read as the end marker
    always_ff @(posedge clk_50) begin
        case (addr)
            ADDR_W'(0): data <= {REG_COM7,  8'h80};   // soft reset
            ADDR_W'(1): data <= {DELAY_TAG, 8'h0A};   // 10 ms settle after reset
            ADDR_W'(2): data <= {REG_CLKRC, 8'h01};
            ADDR_W'(3): data <= {REG_COM7,  8'h04};   // RGB output
            ADDR_W'(4): data <= {REG_COM15, 8'hD0};   // RGB565, full range
            ADDR_W'(5): data <= {REG_COM3,  8'h00};
            ADDR_W'(6): data <= {REG_TSLB,  8'h04};
            ADDR_W'(7): data <= {REG_COM10, 8'h00};
            default:    data <= END_MARKER;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sccb_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_cfg_seq
//  Description : Walks a {reg_addr, reg_data} table and issues one SCCB write
//                per entry, with delay entries, end marker and per-command
//                timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_cfg_seq
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID         = DEV_ID_DEFAULT,
    parameter int         ADDR_W         = 8,
    parameter int         CLK_HZ         = 50_000_000,
    parameter int         MS_CYCLES      = CLK_HZ / 1000,
    parameter int         TIMEOUT_CYCLES = 65536
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [7:0]        cmd_id,
    output logic [7:0]        cmd_addr,
    output logic [7:0]        cmd_data,
    input  logic              cmd_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] entry_idx
);

    localparam int DLY_W = $clog2(255 * MS_CYCLES + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        r_state, w_state;
    logic [DLY_W-1:0]  r_dly, w_dly;
    logic [TMO_W-1:0]  r_tmo, w_tmo;
    logic [ADDR_W-1:0] w_rom_addr, w_entry_idx;
    logic [7:0]        w_cmd_addr, w_cmd_data;
    logic              w_busy, w_done, w_error;
    logic [DLY_W-1:0]  w_dly_load;

    assign cmd_id     = DEV_ID;
    assign cmd_valid  = (r_state == ST_ISSUE);
    assign w_dly_load = DLY_W'(rom_data[7:0]) * DLY_W'(MS_CYCLES);

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_dly     <= '0;
            r_tmo     <= '0;
            rom_addr  <= '0;
            entry_idx <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_dly     <= w_dly;
            r_tmo     <= w_tmo;
            rom_addr  <= w_rom_addr;
            entry_idx <= w_entry_idx;
            cmd_addr  <= w_cmd_addr;
            cmd_data  <= w_cmd_data;
            busy      <= w_busy;
            done      <= w_done;
            error     <= w_error;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        w_state     = r_state;
        w_dly       = r_dly;
        w_tmo       = r_tmo;
        w_rom_addr  = rom_addr;
        w_entry_idx = entry_idx;
        w_cmd_addr  = cmd_addr;
        w_cmd_data  = cmd_data;
        w_busy      = busy;
        w_done      = done;
        w_error     = error;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_done      = 1'b0;
                    w_error     = 1'b0;
                    w_rom_addr  = '0;
                    w_entry_idx = '0;
                    w_busy      = 1'b1;
                    w_state     = ST_FETCH;
                end
            end
            ST_FETCH: w_state = ST_DECODE;
            ST_DECODE: begin
                w_cmd_addr = rom_data[15:8];
                w_cmd_data = rom_data[7:0];
                if (rom_data == END_MARKER) begin
                    // The end marker is not a working entry, so entry_idx
                    // keeps pointing at the last real one.
                    w_state = ST_FINISH;
                end else begin
                    w_entry_idx = rom_addr;
                    if (rom_data[15:8] == DELAY_TAG) begin
                        if (rom_data[7:0] == 8'h00) begin
                            w_state = ST_NEXT;
                        end else begin
                            w_dly   = w_dly_load;
                            w_state = ST_DELAY;
                        end
                    end else begin
                        w_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    w_tmo   = '0;
                    w_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // cmd_done wins over expiry on the same cycle
                if (cmd_done) begin
                    w_state = ST_NEXT;
                end else if (r_tmo == C_TMO_LAST) begin
                    w_error = 1'b1;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end
            ST_DELAY: begin
                // Stays here for exactly the loaded number of cycles
                if (r_dly != '0) begin
                    w_dly = r_dly - 1'b1;
                end
                if (r_dly <= DLY_W'(1)) begin
                    w_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (&rom_addr) begin
                    w_state = ST_FINISH;
                end else begin
                    w_rom_addr = rom_addr + 1'b1;
                    w_state    = ST_FETCH;
                end
            end
            ST_FINISH: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sccb_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_cfg_seq
//  Description : Directed self-checking bench for sccb_cfg_seq (4-entry table,
//                10-cycle millisecond, 100-cycle timeout) and sccb_cfg_rom.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_cfg_seq;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_id, cmd_addr, cmd_data;
    logic        cmd_done = 1'b0;
    logic        busy, done, error;
    logic [1:0]  entry_idx;

    logic [7:0]  rom_raddr = 8'h00;
    logic [15:0] rom_rdata;

    logic [15:0] tbl [0:3];
    int          total = 0;
    int          bad = 0;
    int          n_acc = 0;
    logic [7:0]  acc_addr [0:31];
    logic [7:0]  acc_data [0:31];

    always #5 clk_50 = ~clk_50;

    sccb_cfg_seq #(
        .ADDR_W         (2),
        .MS_CYCLES      (10),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_done  (cmd_done),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .entry_idx (entry_idx)
    );

    sccb_cfg_rom #(.ADDR_W(8)) u_rom (
        .clk_50 (clk_50),
        .addr   (rom_raddr),
        .data   (rom_rdata)
    );

    // Bench-side table with one cycle of read latency
    always @(posedge clk_50) rom_data <= tbl[rom_addr];

    // Log every accepted command (values are stable across the negedge)
    always @(negedge clk_50) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            acc_addr[n_acc[4:0]] <= cmd_addr;
            acc_data[n_acc[4:0]] <= cmd_data;
            n_acc <= n_acc + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=hung expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic load(input logic [15:0] a, b, c, d);
        tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Returns in the first WAIT_DONE cycle after the accept edge
    task automatic wait_accept();
        int n = 0;
        while (!(cmd_valid && cmd_ready) && n < 300) begin
            tick(1);
            n++;
        end
        chk("accept_seen", 32'(cmd_valid && cmd_ready), 32'd1);
        tick(1);
    endtask

    // cmd_done is raised in WAIT_DONE cycle dly (0 = first cycle)
    task automatic serve(input int dly);
        wait_accept();
        tick(dly);
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            tick(1);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int gap;
        logic stable;

        load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // Reset state
        tick(2);
        chk("reset_vec", 32'({rom_addr, cmd_valid, cmd_addr, cmd_data, busy, done, error, entry_idx}), 32'd0);
        reset_n = 1'b1;
        tick(1);
        chk("post_reset_vec", 32'({rom_addr, cmd_valid, busy, done, error, entry_idx}), 32'd0);
        chk("cmd_id", 32'(cmd_id), 32'h42);

        // Default ROM contents
        rom_raddr = 8'd0; tick(1);
        chk("rom_0", 32'(rom_rdata), 32'h1280);
        rom_raddr = 8'd1; tick(1);
        chk("rom_1", 32'(rom_rdata), 32'hFF0A);
        rom_raddr = 8'd8; tick(1);
        chk("rom_end", 32'(rom_rdata), 32'hFFFF);

        // Two writes; first cmd_done lands on the expiry cycle and must win
        load(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
        cmd_ready = 1'b1;
        base = n_acc;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        serve(99);
        serve(10);
        wait_idle();
        chk("t1_count", 32'(n_acc - base), 32'd2);
        chk("t1_cmd0", 32'({acc_addr[base], acc_data[base]}), 32'h1280);
        chk("t1_cmd1", 32'({acc_addr[base+1], acc_data[base+1]}), 32'h1100);
        chk("t1_flags", 32'({done, busy, error}), 32'b100);
        chk("t1_entry_idx", 32'(entry_idx), 32'd1);

        // Delay entry: 2 ms * 10 cycles between the two writes
        load(16'h1280, 16'hFF02, 16'h1100, 16'hFFFF);
        base = n_acc;
        pulse_start();
        wait_accept();
        tick(5);
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
        gap = 1;
        while (!cmd_valid && gap < 200) begin
            tick(1);
            gap++;
        end
        chk("t2_gap", 32'(gap), 32'd27);
        serve(3);
        wait_idle();
        chk("t2_count", 32'(n_acc - base), 32'd2);
        chk("t2_cmd1", 32'({acc_addr[base+1], acc_data[base+1]}), 32'h1100);
        chk("t2_done_addr", 32'({done, rom_addr}), 32'b111);

        // Back-pressure: command held stable while cmd_ready is low
        load(16'h3A04, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        cmd_ready = 1'b0;
        base = n_acc;
        pulse_start();
        tick(2);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!(cmd_valid === 1'b1 && cmd_addr === 8'h3A && cmd_data === 8'h04)) stable = 1'b0;
            tick(1);
        end
        chk("t3_stable", 32'(stable), 32'd1);
        chk("t3_no_accept", 32'(n_acc - base), 32'd0);
        cmd_ready = 1'b1;
        serve(5);
        wait_idle();
        chk("t3_one_accept", 32'(n_acc - base), 32'd1);
        chk("t3_done", 32'(done), 32'd1);

        // Timeout: no cmd_done, expiry exactly 100 cycles after accept
        load(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
        base = n_acc;
        pulse_start();
        wait_accept();
        tick(99);
        chk("t4_not_yet", 32'({error, busy}), 32'b01);
        tick(1);
        chk("t4_flags", 32'({error, done, busy, cmd_valid}), 32'b1000);
        chk("t4_entry_idx", 32'(entry_idx), 32'd0);
        pulse_start();
        chk("t4_err_cleared", 32'({error, busy}), 32'b01);
        serve(5);
        serve(5);
        wait_idle();
        chk("t4_rerun", 32'({done, error}), 32'b10);
        chk("t4_count", 32'(n_acc - base), 32'd3);

        // No end marker: all four entries issued, stops at the last address
        load(16'h1201, 16'h1102, 16'h1003, 16'h0F04);
        base = n_acc;
        pulse_start();
        for (int i = 0; i < 4; i++) serve(2);
        wait_idle();
        chk("t5_count", 32'(n_acc - base), 32'd4);
        chk("t5_last", 32'({acc_addr[base+3], acc_data[base+3]}), 32'h0F04);
        chk("t5_done_addr", 32'({done, rom_addr, entry_idx}), 32'b11111);

        // Asynchronous reset during WAIT_DONE of the second write
        load(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
        pulse_start();
        serve(4);
        wait_accept();
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_reset", 32'({rom_addr, cmd_valid, cmd_addr, cmd_data, busy, done, error, entry_idx}), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        // Start pulse while busy is ignored
        base = n_acc;
        pulse_start();
        serve(4);
        wait_accept();
        chk("t6_in_second", 32'({rom_addr, busy}), 32'b011);
        pulse_start();
        tick(2);
        chk("t6_start_ignored", 32'({rom_addr, busy, cmd_valid}), 32'b0110);
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
        wait_idle();
        chk("t6_done", 32'({done, error}), 32'b10);
        chk("t6_count", 32'(n_acc - base), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sccb_cfg_seq.md
Name: sccb_cfg_seq

Overview:
Camera register configuration sequencer that drives the SCCB master. After a start pulse it walks a synchronous ROM of 16-bit entries {reg_addr, reg_data} and issues one SCCB write command per entry through a valid/ready plus done handshake. It supports delay entries (needed after soft reset of the sensor), an end marker, and a per-command timeout. It sits between the top-level init logic and the SCCB master.

Parameters:
DEV_ID, 8'h42, SCCB write device ID placed on cmd_id.
ADDR_W, 8, ROM address width; table depth is 2**ADDR_W entries.
CLK_HZ, 50_000_000, clk_50 frequency.
MS_CYCLES, CLK_HZ/1000, clk_50 cycles per millisecond of delay.
TIMEOUT_CYCLES, 65536, maximum cycles from command accept to cmd_done.

Ports:
clk_50  in  1  system clock
reset_n  in  1  asynchronous reset, active-low
start  in  1  single-cycle pulse that begins a configuration run
rom_addr  out  ADDR_W  ROM read address
rom_data  in  16  ROM entry; [15:8] reg address, [7:0] data; valid 1 cycle after rom_addr
cmd_valid  out  1  write command request to the SCCB master
cmd_ready  in  1  SCCB master can accept a command
cmd_id  out  8  device ID, tied to DEV_ID
cmd_addr  out  8  register address
cmd_data  out  8  register value
cmd_done  in  1  single-cycle pulse: SCCB write completed
busy  out  1  run in progress
done  out  1  last run completed successfully (sticky)
error  out  1  last run aborted on timeout (sticky)
entry_idx  out  ADDR_W  index of the current or aborted entry

Behaviour:
- Reset: the sequencer enters IDLE. rom_addr=0, cmd_valid=0, cmd_addr=0, cmd_data=0, busy=0, done=0, error=0, entry_idx=0, and all counters are 0.
- States are IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, NEXT, FINISH.
- IDLE: on start, clear done and error, set rom_addr=0, set busy=1, go to FETCH. Start is ignored in every other state.
- FETCH: wait one cycle for ROM latency, then go to DECODE.
- DECODE: latch rom_data into cmd_addr and cmd_data.
  - rom_data==16'hFFFF: end marker, go to FINISH.
  - rom_data[15:8]==8'hFF with any other data: delay entry, load the delay counter with rom_data[7:0]*MS_CYCLES, go to DELAY. Data 0 means no delay; go to NEXT.
  - Otherwise go to ISSUE.
- ISSUE: hold cmd_valid=1 with stable cmd_addr and cmd_data. The command is accepted on the cycle where cmd_valid && cmd_ready. On that cycle, drop cmd_valid on the next edge, clear the timeout counter, and go to WAIT_DONE.
- WAIT_DONE: on cmd_done, go to NEXT. If the timeout counter reaches TIMEOUT_CYCLES-1 without cmd_done, set error=1 and busy=0, freeze entry_idx, and go to IDLE. A cmd_done on the same cycle as expiry counts as success.
- cmd_done outside WAIT_DONE is ignored.
- DELAY: count down to 0, then go to NEXT. The counter is wide enough for 255*MS_CYCLES, which is 24 bits at default.
- NEXT: if rom_addr is at its maximum (2**ADDR_W-1), go to FINISH. There is no wrap-around. Otherwise increment rom_addr and entry_idx, and go to FETCH.
- FINISH: done=1, busy=0, go to IDLE.
- Minimum per-write overhead outside the SCCB transfer: FETCH + DECODE + ISSUE + NEXT = 4 cycles.
- An asynchronous reset mid-run returns every signal to its reset values immediately. An in-flight SCCB transfer is the master's responsibility.
- cmd_id is constant DEV_ID.

Decomposition:
- Shared package sccb_pkg holds:
  - state encoding typedef
  - END_MARKER = 16'hFFFF
  - DELAY_TAG = 8'hFF
  - DEV_ID default 8'h42
  - OV7670 register address constants (COM7 = 8'h12 and similar)
- Sub-module sccb_cfg_rom: synchronous ROM with 1-cycle latency holding the default sensor table. It is instantiated beside the sequencer at top level, not inside it.

Test Plan:
- Table {1280, 1100, FFFF}, start pulse, master ready=1, done 100 cycles after accept → two commands, (12,80) then (11,00). Then done=1, busy=0, error=0, entry_idx=1.
- Table {1280, FF02, 1100, FFFF}, with MS_CYCLES overridden to 10 → gap between the first cmd_done and the second cmd_valid is exactly 20 delay cycles plus FETCH/DECODE/NEXT overhead.
- cmd_ready held low 50 cycles with table {3A04, FFFF} → cmd_valid stays high, cmd_addr=3A and cmd_data=04 stay stable, and exactly one command is accepted.
- cmd_done never asserted, TIMEOUT_CYCLES=100 → error=1, done=0, busy=0 exactly 100 cycles after accept, entry_idx=0. A following start clears error and reruns the table.
- Table with no end marker and ADDR_W=2 → exactly 4 commands issued, then done=1 and rom_addr=3.
- reset_n pulsed low during WAIT_DONE, then start pulsed during busy → the reset pulse returns all outputs to reset values. The start pulse during busy is ignored: no restart and rom_addr unchanged.
